// File: rtl/led_blink_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_driver
// Purpose  : Drives a single lamp output from commands received over a
//            valid/ready handshake. A lamp can be held steadily off, held
//            steadily on, or blinked with a programmable half-period.
//            A blink can repeat a programmable number of on/off cycles or
//            run forever. Typical uses are amber flashing in a traffic-light
//            controller and N-flash acknowledgements of a key toggle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV    system clock cycles per timing tick (2..65535)
//   PER_W       width of cmd_period / cmd_count
// Ports
//   Sys_CLK     in   1      system clock, all logic on the rising edge
//   Sys_RST_N   in   1      asynchronous active-low reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      command accepted when cmd_valid & cmd_ready
//   cmd_mode    in   2      00 OFF, 01 ON, 10 BLINK, 11 reserved (acts as OFF)
//   cmd_period  in   PER_W  blink half-period in ticks (0 behaves as 1)
//   cmd_count   in   PER_W  blink on/off cycles (0 = blink forever)
//   abort       in   1      synchronous return to idle, beats cmd_valid
//   led         out  1      registered lamp drive
//   busy        out  1      registered, high while blinking
//   done        out  1      registered one-cycle pulse at end of finite blink
// ============================================================================
module led_blink_driver #(
  parameter int TICK_DIV = 2500,
  parameter int PER_W    = 8
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [PER_W-1:0] cmd_period,
  input  logic [PER_W-1:0] cmd_count,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]       MODE_ON    = 2'b01;
  localparam logic [1:0]       MODE_BLINK = 2'b10;
  localparam logic [15:0]      PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [PER_W-1:0] PER_ZERO   = '0;
  localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEADY = 2'd1,
    ST_B_ON   = 2'd2,
    ST_B_OFF  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [15:0]      presc_q,  presc_d;
  logic [PER_W-1:0] phase_q,  phase_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] count_q,  count_d;
  logic [PER_W-1:0] remain_q, remain_d;
  logic             led_q,    led_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic tick;
  logic in_blink;
  logic accept;
  logic phase_end;

  assign tick     = (presc_q == PRESC_LAST);
  assign in_blink = (state_q == ST_B_ON) || (state_q == ST_B_OFF);

  // A finite blink must run to completion; everything else can be preempted.
  assign cmd_ready = !(in_blink && (count_q != PER_ZERO));

  // abort wins over a command presented in the same cycle.
  assign accept    = cmd_valid && cmd_ready && !abort;

  assign phase_end = tick && (phase_q == (period_q - PER_ONE));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    period_d = period_q;
    count_d  = count_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    presc_d  = tick ? 16'd0 : (presc_q + 16'd1);

    if (abort) begin
      state_d  = ST_IDLE;
      presc_d  = 16'd0;
      phase_d  = PER_ZERO;
      remain_d = PER_ZERO;
    end else if (accept) begin
      // Restarting the prescaler makes every phase exactly P*TICK_DIV cycles
      // long, independent of when the command arrived.
      presc_d  = 16'd0;
      phase_d  = PER_ZERO;
      remain_d = PER_ZERO;
      case (cmd_mode)
        MODE_ON: begin
          state_d = ST_STEADY;
        end
        MODE_BLINK: begin
          state_d  = ST_B_ON;
          period_d = (cmd_period == PER_ZERO) ? PER_ONE : cmd_period;
          count_d  = cmd_count;
          remain_d = cmd_count;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      case (state_q)
        ST_B_ON: begin
          if (phase_end) begin
            state_d = ST_B_OFF;
            phase_d = PER_ZERO;
          end else if (tick) begin
            phase_d = phase_q + PER_ONE;
          end
        end
        ST_B_OFF: begin
          if (phase_end) begin
            phase_d = PER_ZERO;
            if (count_q == PER_ZERO) begin
              state_d = ST_B_ON;
            end else if (remain_q == PER_ONE) begin
              // Last off phase of a finite blink: counter stays at 1.
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_B_ON;
              remain_d = remain_q - PER_ONE;
            end
          end else if (tick) begin
            phase_d = phase_q + PER_ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    led_d  = (state_d == ST_STEADY) || (state_d == ST_B_ON);
    busy_d = (state_d == ST_B_ON) || (state_d == ST_B_OFF);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      state_q  <= ST_IDLE;
      presc_q  <= 16'd0;
      phase_q  <= PER_ZERO;
      period_q <= PER_ONE;
      count_q  <= PER_ZERO;
      remain_q <= PER_ZERO;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_driver
// Purpose  : Self-checking bench for led_blink_driver (TICK_DIV=4, PER_W=8).
//            Each command pushes its expected per-cycle outputs to a queue;
//            a negedge checker pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_driver;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_period;
  logic [7:0] cmd_count;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;

  led_blink_driver #(
    .TICK_DIV (4),
    .PER_W    (8)
  ) dut (
    .Sys_CLK    (clk),
    .Sys_RST_N  (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .cmd_count  (cmd_count),
    .abort      (abort),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic led;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] period;
    logic [7:0] count;
    int         half;   // cycles per blink half-period (P_eff * TICK_DIV)
    int         hold;   // cycles observed after the accept edge
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Scoreboard checker: one expected record per clock cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (led !== e.led || busy !== e.busy || done !== e.done || cmd_ready !== e.ready) begin
        n_err++;
        $display("FAIL outputs t=%0t actual led=%b busy=%b done=%b ready=%b required led=%b busy=%b done=%b ready=%b",
                 $time, led, busy, done, cmd_ready, e.led, e.busy, e.done, e.ready);
      end
    end
  end

  // Expected outputs for `hold` cycles following the accept edge of a command.
  task automatic gen(input logic [1:0] mode, input int n, input int half, input int hold);
    for (int k = 0; k < hold; k++) begin
      exp_t e;
      int   total;
      e.led = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
      total = 2 * half * n;
      if (mode == 2'b01) begin
        e.led = 1'b1;
      end else if (mode == 2'b10) begin
        if (n == 0 || k < total) begin
          e.led   = ((k / half) % 2) == 0;
          e.busy  = 1'b1;
          e.ready = (n == 0);
        end else if (k == total) begin
          e.done = 1'b1;
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command in the current cycle, then runs `hold` cycles so the
  // caller ends up in the last observed cycle, ready for the next command.
  task automatic apply(input logic [1:0] mode, input logic [7:0] p, input logic [7:0] n,
                       input int half, input int hold);
    cmd_valid  = 1'b1;
    cmd_mode   = mode;
    cmd_period = p;
    cmd_count  = n;
    step();
    cmd_valid  = 1'b0;
    gen(mode, int'(n), half, hold);
    repeat (hold - 1) step();
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s actual led=%b busy=%b done=%b ready=%b required led=0 busy=0 done=0 ready=1",
               name, led, busy, done, cmd_ready);
    end
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{2'b00, 8'd0,   8'd0, 1,    10};
    vt[1]  = '{2'b01, 8'd0,   8'd0, 1,    10};
    vt[2]  = '{2'b11, 8'd0,   8'd0, 1,    6};
    vt[3]  = '{2'b10, 8'd2,   8'd3, 8,    53};
    vt[4]  = '{2'b10, 8'd0,   8'd0, 4,    37};
    vt[5]  = '{2'b01, 8'd0,   8'd0, 1,    8};
    vt[6]  = '{2'b10, 8'd1,   8'd0, 4,    7};
    vt[7]  = '{2'b10, 8'd2,   8'd1, 8,    20};
    vt[8]  = '{2'b10, 8'd1,   8'd1, 4,    12};
    vt[9]  = '{2'b10, 8'd3,   8'd2, 12,   51};
    vt[10] = '{2'b10, 8'd255, 8'd1, 1020, 2044};
    vt[11] = '{2'b10, 8'd5,   8'd0, 20,   50};
    vt[12] = '{2'b00, 8'd0,   8'd0, 1,    5};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'b00;
    cmd_period = 8'd0;
    cmd_count  = 8'd0;
    abort      = 1'b0;

    #3;
    check_idle("reset_state");
    #19 rst_n = 1'b1;

    // Quiet period after reset release.
    step();
    gen(2'b00, 0, 1, 100);
    repeat (99) step();

    // Table-driven commands.
    for (int i = 0; i < 13; i++) begin
      apply(vt[i].mode, vt[i].period, vt[i].count, vt[i].half, vt[i].hold);
    end

    // Command held off during a finite blink, accepted right after done.
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_period = 8'd1; cmd_count = 8'd2;
    step();
    cmd_valid = 1'b0;
    gen(2'b10, 2, 4, 17);
    gen(2'b01, 0, 1, 6);
    repeat (3) step();
    cmd_valid = 1'b1; cmd_mode = 2'b01;
    repeat (14) step();
    cmd_valid = 1'b0;
    repeat (5) step();

    // Abort during a finite blink, with a competing command: no done pulse.
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_period = 8'd1; cmd_count = 8'd2;
    step();
    cmd_valid = 1'b0;
    gen(2'b10, 2, 4, 5);
    gen(2'b00, 0, 1, 20);
    repeat (4) step();
    abort = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'b01;
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    repeat (19) step();

    // Abort during an infinite blink while ready is high: abort must win.
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_period = 8'd1; cmd_count = 8'd0;
    step();
    cmd_valid = 1'b0;
    gen(2'b10, 0, 4, 7);
    gen(2'b00, 0, 1, 20);
    repeat (6) step();
    abort = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'b01;
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    repeat (19) step();

    // Asynchronous reset in the middle of an on phase.
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_period = 8'd2; cmd_count = 8'd3;
    step();
    cmd_valid = 1'b0;
    gen(2'b10, 3, 8, 4);
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1 check_idle("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_idle("held_reset");
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    apply(2'b11, 8'd7, 8'd4, 1, 8);
    apply(2'b10, 8'd1, 8'd1, 4, 12);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
